// File: rtl/lfsr_press_gen.sv
// lfsr_press_gen
//   Pseudo-random "button press" generator. A 10-bit Fibonacci XNOR LFSR
//   produces a new random value on every enabled cycle. A small FSM compares
//   that value with a difficulty threshold. When the value is above the
//   threshold it emits a one-cycle press pulse, then forces a fixed cooldown
//   before it may press again.
//
// Ports
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Enable     in   1 = run; 0 = hold LFSR, return FSM to IDLE, no presses
//   Load       in   1 = load Seed into the LFSR (all-ones seed loads zero)
//   Seed       in   LFSR load value
//   Threshold  in   unsigned difficulty threshold (press when Rand > Threshold)
//   Rand       out  current LFSR state, registered
//   Press      out  registered one-cycle press pulse
//
// FSM states
//   state | meaning
//   IDLE  | generator disabled or just reset; no compare performed
//   ARMED | compare Rand against Threshold each cycle, press when greater
//   COOL  | forced idle after a press; counter runs down to re-arm
module lfsr_press_gen #(
  parameter int WIDTH    = 10,
  parameter int COOLDOWN = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Load,
  input  logic [WIDTH-1:0] Seed,
  input  logic [WIDTH-1:0] Threshold,
  output logic [WIDTH-1:0] Rand,
  output logic             Press
);

  localparam int               CNT_W    = $clog2(COOLDOWN + 1);
  localparam logic [WIDTH-1:0] LOCKUP   = '1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             press_next;
  logic [WIDTH-1:0] rand_next;
  logic [WIDTH-1:0] rand_step;
  logic             feedback;

  // Taps 10 and 7 (bits 9 and 6). With XNOR feedback the all-ones word is
  // the one state outside the maximal cycle, so zero is a legal start point.
  assign feedback  = ~(Rand[9] ^ Rand[6]);
  assign rand_step = {Rand[WIDTH-2:0], feedback};

  // Load wins over everything; an all-ones value, whether loaded or reached
  // through an upset, is never allowed to persist because it would lock up.
  always_comb begin
    rand_next = Rand;
    if (Load) begin
      rand_next = (Seed == LOCKUP) ? '0 : Seed;
    end else if (Rand == LOCKUP) begin
      rand_next = '0;
    end else if (Enable) begin
      rand_next = rand_step;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Rand <= '0;
    end else begin
      Rand <= rand_next;
    end
  end

  // Load does not touch the FSM; the compare always sees the pre-edge Rand.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press_next = 1'b0;
    if (!Enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = ARMED;
        end
        ARMED: begin
          if (Rand > Threshold) begin
            press_next = 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = COOL;
          end
        end
        COOL: begin
          // Re-arm on the edge that sees count 1, so a press repeats every
          // COOLDOWN+1 cycles at the maximum rate.
          if (cnt <= CNT_ONE) begin
            cnt_next   = '0;
            state_next = ARMED;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      Press <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      Press <= press_next;
    end
  end

endmodule

// File: tb/tb_lfsr_press_gen.sv
module tb_lfsr_press_gen;

  localparam int COOLDOWN = 4;
  localparam int PERIOD   = 1023;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       ld;
  logic [9:0] seed;
  logic [9:0] thr;
  logic [9:0] rand_o;
  logic       press_o;

  lfsr_press_gen #(.WIDTH(10), .COOLDOWN(COOLDOWN)) dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .Enable    (en),
    .Load      (ld),
    .Seed      (seed),
    .Threshold (thr),
    .Rand      (rand_o),
    .Press     (press_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {Rand, Press} after each functional edge.
  logic [10:0] exp_q[$];

  // Reference sequence: position table of the maximal-length cycle from 0.
  logic [9:0] seq[PERIOD];
  int         idx[1024];

  // Behavioural model state
  logic [9:0] m_rand;
  bit         m_idle;
  int         m_cool;

  bit         prev_press;
  bit         seen_lockup;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_rand = '0;
    m_idle = 1'b1;
    m_cool = 0;
  endtask

  // Predict the result of the coming edge from the inputs now driven.
  task automatic model_step();
    logic [9:0] r_n;
    logic       p_n;
    p_n = 1'b0;
    if (!en) begin
      m_idle = 1'b1;
      m_cool = 0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (m_rand > thr) begin
      p_n    = 1'b1;
      m_cool = COOLDOWN;
    end
    if (ld)      r_n = (seed == 10'h3FF) ? 10'h000 : seed;
    else if (en) r_n = seq[(idx[m_rand] + 1) % PERIOD];
    else         r_n = m_rand;
    m_rand = r_n;
    exp_q.push_back({r_n, p_n});
  endtask

  task automatic cyc(input bit e, input bit l, input logic [9:0] s, input logic [9:0] t);
    @(negedge clk);
    en   = e;
    ld   = l;
    seed = s;
    thr  = t;
    model_step();
  endtask

  // Reset pulse between edges; outputs must clear without a clock edge.
  task automatic reset_pulse();
    @(negedge clk);
    en = 1'b0;
    ld = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rand", 32'(rand_o), 32'h0);
    check("async_press", 32'(press_o), 32'h0);
    #1 rst_n = 1'b1;
    model_reset();
    model_step();
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(posedge clk) begin
    logic [10:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({rand_o, press_o} !== e) begin
        errors++;
        $display("FAIL out t=%0t got rand=%h press=%b want rand=%h press=%b",
                 $time, rand_o, press_o, e[10:1], e[0]);
      end
      checks++;
      if (press_o && prev_press) begin
        errors++;
        $display("FAIL press_twice t=%0t got two consecutive presses want single pulse", $time);
      end
    end
    if (rand_o == 10'h3FF) seen_lockup = 1'b1;
    prev_press = press_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < PERIOD; i++) begin
      seq[i] = r;
      idx[r] = i;
      r = {r[8:0], ~(r[9] ^ r[6])};
    end
    idx[10'h3FF] = 0;
    prev_press  = 1'b0;
    seen_lockup = 1'b0;

    rst_n = 1'b0;
    en    = 1'b0;
    ld    = 1'b0;
    seed  = '0;
    thr   = 10'h3FF;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_rand", 32'(rand_o), 32'h0);
    check("reset_press", 32'(press_o), 32'h0);
    rst_n = 1'b1;
    model_step();

    // Full period with no presses; first nine values are the documented list.
    for (int i = 0; i < PERIOD; i++) begin
      cyc(1'b1, 1'b0, 10'h000, 10'h3FF);
      if (i == 7) begin
        @(posedge clk);
        #2;
        check("seq_0fe", 32'(rand_o), 32'h0FE);
      end
    end
    @(posedge clk);
    #2;
    check("period_back_to_0", 32'(rand_o), 32'h0);
    check("lockup_never_seen", 32'(seen_lockup), 32'h0);

    // Threshold 0 from reset: press two cycles after enable, then period 5.
    reset_pulse();
    for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0, 10'h000, 10'h000);

    // Loads: all-ones seed, then load while disabled keeps FSM idle.
    cyc(1'b1, 1'b1, 10'h3FF, 10'h000);
    cyc(1'b0, 1'b1, 10'h155, 10'h000);
    cyc(1'b0, 1'b0, 10'h000, 10'h000);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'h000, 10'h000);

    // Enable dropped during cooldown, then re-enabled.
    reset_pulse();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 10'h000, 10'h000);
    cyc(1'b0, 1'b0, 10'h000, 10'h000);
    cyc(1'b0, 1'b0, 10'h000, 10'h000);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 10'h000, 10'h000);

    // Reset pulse mid-cooldown, then the sequence restarts from zero.
    reset_pulse();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 10'h000, 10'h000);
    reset_pulse();
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 10'h000, 10'h3FF);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        logic [9:0] s, t;
        s = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
        case ($urandom_range(0, 3))
          0:       t = 10'h000;
          1:       t = 10'h3FF;
          default: t = 10'($urandom_range(0, 1023));
        endcase
        cyc($urandom_range(0, 15) != 0, $urandom_range(0, 19) == 0, s, t);
      end
    end

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
